jk_reg_bank: RTL and testbench

Parametrised bank of WIDTH flip-flop cells with run-time-selectable next-state rule (JK, SR, D, T), synchronous parallel load, an optional master-slave output stage, illegal-SR detection and per-bit change strobes. It is the general-purpose successor to the single-bit JK and master-slave JK cells. It sits wherever the design needs a small control/status register with flip-flop-style bit manipulation.

---
 rtl/jk_reg_pkg.sv | 22 ++
 rtl/jk_reg_bank_cell.sv | 47 ++++
 rtl/jk_reg_bank.sv | 124 ++++++++++++
 tb/tb_jk_reg_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/jk_reg_pkg.sv
// jk_reg_pkg
// Shared definitions for the jk_reg_bank register bank:
//   mode_t          - per-bank next-state rule selector
//   WIDTH_MIN/MAX   - legal range for the bank width
//   width_in_range  - elaboration-time range check used by the top level
package jk_reg_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    function automatic bit width_in_range(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/jk_reg_bank_cell.sv
// jk_bit_cell
// Pure next-state logic for one flip-flop cell of the bank.
// Ports:
//   mode    in  next-state rule (JK, SR, D, T)
//   j       in  J / S / D / T input
//   k       in  K / R input (ignored in D and T)
//   cur     in  current stored bit
//   nxt     out next bit if the cell is enabled
//   illegal out SR mode with S=R=1 (cell holds in that case)
module jk_bit_cell
    import jk_reg_pkg::*;
(
    input  mode_t mode,
    input  logic  j,
    input  logic  k,
    input  logic  cur,
    output logic  nxt,
    output logic  illegal
);

    always_comb begin
        nxt     = cur;
        illegal = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~cur;
                    default: nxt = cur;
                endcase
            end
            MODE_SR: begin
                case ({j, k})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   illegal = 1'b1;  // bit holds, flag raised
                    default: nxt = cur;
                endcase
            end
            MODE_D:  nxt = j;
            MODE_T:  nxt = j ? ~cur : cur;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/jk_reg_bank.sv
// jk_reg_bank
// Bank of WIDTH flip-flop cells with run-time selectable next-state rule,
// synchronous parallel load, optional master-slave output stage, sticky
// illegal-SR flag and per-bit change strobes.
// Ports:
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset
//   en       in  cell update enable (master holds when 0)
//   mode     in  00 JK, 01 SR, 10 D, 11 T
//   j, k     in  per-bit cell inputs
//   load     in  synchronous parallel load, overrides en/mode
//   load_val in  value loaded into the master
//   clr_err  in  clears err (a simultaneous new error wins)
//   q        out bank output (slave when MS_STAGE=1, else master)
//   q_bar    out ~q
//   err      out sticky illegal-SR flag
//   chg      out one-cycle pulse per bit when that bit of q changed
module jk_reg_bank
    import jk_reg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit MS_STAGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             err,
    output logic [WIDTH-1:0] chg
);

    if (!width_in_range(WIDTH)) begin : g_width_check
        $error("jk_reg_bank: WIDTH must be in 1..64");
    end

    mode_t            mode_sel;
    logic [WIDTH-1:0] master;
    logic [WIDTH-1:0] master_next;
    logic [WIDTH-1:0] cell_next;
    logic [WIDTH-1:0] cell_ill;
    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] chg_r;
    logic             err_r;
    logic             err_set;

    assign mode_sel = mode_t'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_bit_cell u_cell (
            .mode    (mode_sel),
            .j       (j[i]),
            .k       (k[i]),
            .cur     (master[i]),
            .nxt     (cell_next[i]),
            .illegal (cell_ill[i])
        );
    end

    always_comb begin
        master_next = master;
        if (load) begin
            master_next = load_val;
        end else if (en) begin
            master_next = cell_next;
        end
    end

    // cell_ill is only ever raised in SR mode, so no extra mode qualifier.
    assign err_set = en & ~load & (|cell_ill);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            master <= '0;
        end else begin
            master <= master_next;
        end
    end

    if (MS_STAGE) begin : g_slave
        logic [WIDTH-1:0] slave;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slave <= '0;
            end else begin
                slave <= master;
            end
        end
        assign q_int  = slave;
        assign q_next = master;        // what the slave takes on the next edge
    end else begin : g_direct
        assign q_int  = master;
        assign q_next = master_next;
    end

    // chg is registered alongside q, so it pulses in the cycle q shows
    // its new value and drops once q is steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_r <= '0;
            err_r <= 1'b0;
        end else begin
            chg_r <= q_next ^ q_int;
            if (err_set) begin
                err_r <= 1'b1;
            end else if (clr_err) begin
                err_r <= 1'b0;
            end
        end
    end

    assign q     = q_int;
    assign q_bar = ~q_int;
    assign err   = err_r;
    assign chg   = chg_r;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank
// Drives a MS_STAGE=0 and a MS_STAGE=1 instance with identical stimulus and
// checks both against a bit-level reference model of the bank.
module tb_jk_reg_bank;
    import jk_reg_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset / DUTs ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, load, clr_err;
    logic [1:0]   mode;
    logic [W-1:0] j, k, load_val;
    logic [W-1:0] q0, qb0, chg0, q1, qb1, chg1;
    logic         err0, err1;

    always #5 clk = ~clk;

    jk_reg_bank #(.WIDTH(W), .MS_STAGE(1'b0)) u_ms0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_val(load_val), .clr_err(clr_err),
        .q(q0), .q_bar(qb0), .err(err0), .chg(chg0)
    );

    jk_reg_bank #(.WIDTH(W), .MS_STAGE(1'b1)) u_ms1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j), .k(k),
        .load(load), .load_val(load_val), .clr_err(clr_err),
        .q(q1), .q_bar(qb1), .err(err1), .chg(chg1)
    );

    // ---------------- scoreboard ----------------
    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_model;   // master
    logic [W-1:0] s_model;   // slave
    logic         e_model;   // err

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference next-state for the whole bank when enabled.
    function automatic logic [W-1:0] model_next(input logic [1:0] md, input logic [W-1:0] jj,
                                                input logic [W-1:0] kk, input logic [W-1:0] cur,
                                                output logic ill);
        logic [W-1:0] r;
        r   = cur;
        ill = 1'b0;
        for (int b = 0; b < W; b++) begin
            unique case (md)
                2'b00: r[b] = (jj[b] & ~cur[b]) | (~kk[b] & cur[b]);
                2'b01: begin
                    if (jj[b] & kk[b]) ill = 1'b1;
                    else if (jj[b])    r[b] = 1'b1;
                    else if (kk[b])    r[b] = 1'b0;
                end
                2'b10: r[b] = jj[b];
                2'b11: r[b] = cur[b] ^ jj[b];
            endcase
        end
        return r;
    endfunction

    // Called just after a falling edge with inputs already driven; returns
    // at the following falling edge.
    task automatic step(input string tag);
        logic [W-1:0] m_next;
        logic         ill;
        logic         e_next;
        ill    = 1'b0;
        m_next = m_model;
        if (load)    m_next = load_val;
        else if (en) m_next = model_next(mode, j, k, m_model, ill);
        if (!load && en && ill) e_next = 1'b1;
        else if (clr_err)       e_next = 1'b0;
        else                    e_next = e_model;
        exp_q.push_back(m_next);   // q of MS_STAGE=0
        exp_q.push_back(m_model);  // q of MS_STAGE=1
        @(posedge clk);
        #1;
        check({tag, "/q_ms0"},   q0,   exp_q.pop_front());
        check({tag, "/q_ms1"},   q1,   exp_q.pop_front());
        check({tag, "/qb_ms0"},  qb0,  ~m_next);
        check({tag, "/qb_ms1"},  qb1,  ~m_model);
        check({tag, "/chg_ms0"}, chg0, m_next ^ m_model);
        check({tag, "/chg_ms1"}, chg1, m_model ^ s_model);
        check({tag, "/err_ms0"}, W'(err0), W'(e_next));
        check({tag, "/err_ms1"}, W'(err1), W'(e_next));
        s_model = m_model;
        m_model = m_next;
        e_model = e_next;
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/q_ms0"},   q0,   '0);
        check({tag, "/q_ms1"},   q1,   '0);
        check({tag, "/qb_ms0"},  qb0,  '1);
        check({tag, "/qb_ms1"},  qb1,  '1);
        check({tag, "/chg_ms0"}, chg0, '0);
        check({tag, "/chg_ms1"}, chg1, '0);
        check({tag, "/err_ms0"}, W'(err0), '0);
        check({tag, "/err_ms1"}, W'(err1), '0);
    endtask

    task automatic async_reset(input string tag);
        #2;                       // between edges: proves the reset is asynchronous
        rst_n = 1'b0;
        #1;
        check_reset(tag);
        m_model = '0;
        s_model = '0;
        e_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic l, input logic e, input logic [1:0] md,
                          input logic [W-1:0] jj, input logic [W-1:0] kk,
                          input logic [W-1:0] lv, input logic ce);
        load = l; en = e; mode = md; j = jj; k = kk; load_val = lv; clr_err = ce;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0);
        m_model = '0; s_model = '0; e_model = 1'b0;
        #1;
        check_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // parallel load
        set_in(1'b1, 1'b0, 2'b00, '0, '0, 8'hA5, 1'b0); step("load");
        set_in(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0);    step("load_settle");

        // JK: every (j,k) combination appears across the bits
        set_in(1'b0, 1'b1, 2'b00, 8'hF0, 8'h3C, '0, 1'b0); step("jk");
        set_in(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0);       step("jk_settle");
        step("jk_steady");

        // reset with a master value still pending for the slave
        set_in(1'b1, 1'b0, 2'b00, '0, '0, 8'h3C, 1'b0); step("pre_reset");
        set_in(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0);
        async_reset("mid_reset");
        step("post_reset");

        // SR illegal and sticky err
        set_in(1'b0, 1'b1, 2'b01, 8'h03, 8'h01, '0, 1'b0); step("sr_illegal");
        set_in(1'b0, 1'b0, 2'b01, '0, '0, '0, 1'b0);       step("sr_hold");
        set_in(1'b0, 1'b1, 2'b01, 8'h03, 8'h01, '0, 1'b1); step("sr_set_wins");
        set_in(1'b0, 1'b0, 2'b01, '0, '0, '0, 1'b1);       step("sr_clear");
        set_in(1'b0, 1'b0, 2'b01, '0, '0, '0, 1'b0);       step("sr_cleared");

        // D then T twice
        set_in(1'b0, 1'b1, 2'b10, 8'h5A, 8'hFF, '0, 1'b0); step("d");
        set_in(1'b0, 1'b1, 2'b11, 8'hFF, 8'h00, '0, 1'b0); step("t1");
        step("t2");
        set_in(1'b0, 1'b0, 2'b11, '0, '0, '0, 1'b0);       step("t_settle");

        // load beats en/mode
        set_in(1'b1, 1'b1, 2'b11, 8'hFF, 8'hFF, 8'hC3, 1'b0); step("prio_load");
        // illegal SR pattern under load: no error
        set_in(1'b1, 1'b1, 2'b01, 8'hFF, 8'hFF, 8'h3C, 1'b0); step("prio_load_sr");

        // hold with random j/k/mode
        for (int n = 0; n < 5; n++) begin
            set_in(1'b0, 1'b0, 2'($urandom_range(0, 3)), W'($urandom_range(0, 255)),
                   W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);
            step("hold");
        end

        // random mix
        for (int n = 0; n < 30; n++) begin
            set_in(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), W'($urandom_range(0, 255)),
                   W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
